bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter_if.sv | 27 ++
 rtl/bus_arbiter.sv | 65 ++++++
 tb/tb_bus_arbiter.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if: two-master request/grant bus plus the shared bus-side signals.
interface bus_arbiter_if #(parameter int AW = 32, parameter int DW = 32);
  logic          m0_req, m1_req;
  logic [AW-1:0] m0_addr, m1_addr;
  logic          m0_read, m1_read;
  logic          m0_write, m1_write;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          m0_gnt, m1_gnt;
  logic          m0_ack, m1_ack;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic [AW-1:0] addr_bus;
  logic          m_read, m_write;
  logic [DW-1:0] d_t_mem, d_f_mem;
  logic          conflict;
  modport slave (
    input  m0_req, m0_addr, m0_read, m0_write, m0_wdata,
    input  m1_req, m1_addr, m1_read, m1_write, m1_wdata, d_f_mem,
    output m0_gnt, m0_ack, m0_rdata, m1_gnt, m1_ack, m1_rdata,
    output addr_bus, m_read, m_write, d_t_mem, conflict
  );
  modport master (
    output m0_req, m0_addr, m0_read, m0_write, m0_wdata,
    output m1_req, m1_addr, m1_read, m1_write, m1_wdata, d_f_mem,
    input  m0_gnt, m0_ack, m0_rdata, m1_gnt, m1_ack, m1_rdata,
    input  addr_bus, m_read, m_write, d_t_mem, conflict
  );
endinterface

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin two-master arbiter with bounded hold and a shared bus mux.
module bus_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int MAX_HOLD = 8
) (
  input logic clk,
  input logic rst,
  bus_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
  localparam logic [7:0] HOLD = 8'(MAX_HOLD);
  state_t state, next;
  logic last, conflict_q, sel0, sel1, ack0, ack1, done;
  logic [7:0] cnt;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  always_comb begin
    sel0 = state == OWN0 && bus.m0_req;
    sel1 = state == OWN1 && bus.m1_req;
    ack0 = sel0 && (bus.m0_read || bus.m0_write);
    ack1 = sel1 && (bus.m1_read || bus.m1_write);
    // hold expires on the ack that reaches the limit, or once already saturated
    done = cnt == HOLD || ((ack0 || ack1) && cnt == HOLD - 8'd1);
    next = state;
    case (state)
      IDLE: next = (bus.m0_req && bus.m1_req) ? (last ? OWN0 : OWN1) :
                   bus.m0_req ? OWN0 : bus.m1_req ? OWN1 : IDLE;
      OWN0: next = !bus.m0_req ? (bus.m1_req ? OWN1 : IDLE) :
                   (bus.m1_req && done) ? OWN1 : OWN0;
      OWN1: next = !bus.m1_req ? (bus.m0_req ? OWN0 : IDLE) :
                   (bus.m0_req && done) ? OWN0 : OWN1;
      default: next = IDLE;
    endcase
    addr = sel0 ? bus.m0_addr : sel1 ? bus.m1_addr : '0;
    wdata = sel0 ? bus.m0_wdata : sel1 ? bus.m1_wdata : '0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      last <= 1'b1;
      cnt <= '0;
      conflict_q <= 1'b0;
    end else begin
      state <= next;
      if (next != state) cnt <= '0;
      else if ((ack0 || ack1) && cnt != HOLD) cnt <= cnt + 8'd1;
      if (state == OWN0 && next != OWN0) last <= 1'b0;
      else if (state == OWN1 && next != OWN1) last <= 1'b1;
      conflict_q <= conflict_q | (sel0 && bus.m0_read && bus.m0_write) |
                    (sel1 && bus.m1_read && bus.m1_write);
    end
  assign bus.m0_gnt = state == OWN0;
  assign bus.m1_gnt = state == OWN1;
  assign bus.m0_ack = ack0;
  assign bus.m1_ack = ack1;
  assign bus.m0_rdata = (ack0 && bus.m0_read) ? bus.d_f_mem : '0;
  assign bus.m1_rdata = (ack1 && bus.m1_read) ? bus.d_f_mem : '0;
  assign bus.addr_bus = addr;
  assign bus.d_t_mem = wdata;
  assign bus.m_write = (sel0 && bus.m0_write) || (sel1 && bus.m1_write);
  assign bus.m_read = (sel0 && bus.m0_read && !bus.m0_write) ||
                      (sel1 && bus.m1_read && !bus.m1_write);
  assign bus.conflict = conflict_q;
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed scenario tests for bus_arbiter.
module tb_bus_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  int checks = 0, errors = 0;
  bus_arbiter_if #(.AW(32), .DW(32)) bus ();
  bus_arbiter #(.AW(32), .DW(32), .MAX_HOLD(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task step;
    @(posedge clk);
    #1;
  endtask

  task clear_in;
    bus.m0_req = 0; bus.m0_addr = 0; bus.m0_read = 0; bus.m0_write = 0; bus.m0_wdata = 0;
    bus.m1_req = 0; bus.m1_addr = 0; bus.m1_read = 0; bus.m1_write = 0; bus.m1_wdata = 0;
    bus.d_f_mem = 0;
  endtask

  task test_reset;
    clear_in();
    rst = 1;
    step(); step();
    checks++; if (bus.m0_gnt !== 1'b0) begin errors++; $display("FAIL reset_gnt0: got %b want 0", bus.m0_gnt); end
    checks++; if (bus.m1_gnt !== 1'b0) begin errors++; $display("FAIL reset_gnt1: got %b want 0", bus.m1_gnt); end
    checks++; if (bus.conflict !== 1'b0) begin errors++; $display("FAIL reset_conflict: got %b want 0", bus.conflict); end
    checks++; if ({bus.addr_bus, bus.m_read, bus.m_write} !== 34'h0) begin errors++; $display("FAIL reset_bus: got %h want 0", {bus.addr_bus, bus.m_read, bus.m_write}); end
    rst = 0;
    step();
  endtask

  task test_tie_hold;
    bus.m0_req = 1; bus.m0_read = 1; bus.m1_req = 1; bus.m1_read = 1;
    #1;
    checks++; if (bus.m0_gnt !== 1'b0) begin errors++; $display("FAIL tie_latency: got %b want 0", bus.m0_gnt); end
    step();
    for (int i = 0; i < 8; i++) begin
      checks++; if ({bus.m0_gnt, bus.m0_ack, bus.m1_gnt} !== 3'b110) begin errors++; $display("FAIL tie_ack%0d: got %b want 110", i, {bus.m0_gnt, bus.m0_ack, bus.m1_gnt}); end
      step();
    end
    checks++; if ({bus.m0_gnt, bus.m1_gnt, bus.m1_ack} !== 3'b011) begin errors++; $display("FAIL tie_handover: got %b want 011", {bus.m0_gnt, bus.m1_gnt, bus.m1_ack}); end
    clear_in();
    step();
    checks++; if (bus.m1_gnt !== 1'b0) begin errors++; $display("FAIL tie_idle: got %b want 0", bus.m1_gnt); end
  endtask

  task test_read;
    bus.m0_req = 1; bus.m0_read = 1; bus.m0_addr = 32'hA0000000; bus.d_f_mem = 32'h80000041;
    step();
    checks++; if (bus.m0_rdata !== 32'h80000041) begin errors++; $display("FAIL read_rdata0: got %h want 80000041", bus.m0_rdata); end
    checks++; if (bus.m1_rdata !== 32'h0) begin errors++; $display("FAIL read_rdata1: got %h want 0", bus.m1_rdata); end
    checks++; if ({bus.m0_ack, bus.m1_ack, bus.m_read, bus.m_write} !== 4'b1010) begin errors++; $display("FAIL read_strobes: got %b want 1010", {bus.m0_ack, bus.m1_ack, bus.m_read, bus.m_write}); end
    checks++; if (bus.addr_bus !== 32'hA0000000) begin errors++; $display("FAIL read_addr: got %h want a0000000", bus.addr_bus); end
    clear_in();
    step();
  endtask

  task test_round_robin;
    bus.m0_req = 1; bus.m0_write = 1; bus.m1_req = 1; bus.m1_write = 1;
    step();
    checks++; if ({bus.m0_gnt, bus.m1_gnt} !== 2'b01) begin errors++; $display("FAIL rr_tie_m1: got %b want 01", {bus.m0_gnt, bus.m1_gnt}); end
    clear_in();
    step();
  endtask

  task test_write_burst;
    bus.m1_req = 1; bus.m1_write = 1; bus.m1_addr = 32'hC0000004; bus.m1_wdata = 32'h12345678;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if ({bus.m1_gnt, bus.m1_ack, bus.m_write, bus.m_read} !== 4'b1110) begin errors++; $display("FAIL burst_strobe%0d: got %b want 1110", i, {bus.m1_gnt, bus.m1_ack, bus.m_write, bus.m_read}); end
      checks++; if ({bus.addr_bus, bus.d_t_mem} !== {32'hC0000004, 32'h12345678}) begin errors++; $display("FAIL burst_bus%0d: got %h want c000000412345678", i, {bus.addr_bus, bus.d_t_mem}); end
    end
    bus.m1_req = 0;
    #1;
    checks++; if ({bus.addr_bus, bus.d_t_mem, bus.m_write, bus.m1_ack} !== 66'h0) begin errors++; $display("FAIL burst_drop: got %h want 0", {bus.addr_bus, bus.d_t_mem, bus.m_write, bus.m1_ack}); end
    step();
    checks++; if ({bus.m0_gnt, bus.m1_gnt, bus.m_write, bus.addr_bus} !== 35'h0) begin errors++; $display("FAIL burst_idle: got %h want 0", {bus.m0_gnt, bus.m1_gnt, bus.m_write, bus.addr_bus}); end
    clear_in();
  endtask

  task test_handover;
    bus.m0_req = 1; bus.m0_read = 1;
    step();
    checks++; if (bus.m0_gnt !== 1'b1) begin errors++; $display("FAIL ho_own0: got %b want 1", bus.m0_gnt); end
    bus.m0_req = 0; bus.m1_req = 1; bus.m1_write = 1;
    #1;
    checks++; if ({bus.m0_gnt, bus.m_read, bus.m0_ack} !== 3'b100) begin errors++; $display("FAIL ho_drop: got %b want 100", {bus.m0_gnt, bus.m_read, bus.m0_ack}); end
    step();
    checks++; if ({bus.m0_gnt, bus.m1_gnt} !== 2'b01) begin errors++; $display("FAIL ho_no_bubble: got %b want 01", {bus.m0_gnt, bus.m1_gnt}); end
    clear_in();
    step();
  endtask

  task test_saturate;
    bus.m0_req = 1; bus.m0_write = 1;
    repeat (13) step();
    checks++; if ({bus.m0_gnt, bus.m0_ack} !== 2'b11) begin errors++; $display("FAIL sat_keep: got %b want 11", {bus.m0_gnt, bus.m0_ack}); end
    bus.m1_req = 1; bus.m1_write = 1;
    #1;
    checks++; if ({bus.m0_gnt, bus.m1_gnt} !== 2'b10) begin errors++; $display("FAIL sat_pre: got %b want 10", {bus.m0_gnt, bus.m1_gnt}); end
    step();
    checks++; if ({bus.m0_gnt, bus.m1_gnt} !== 2'b01) begin errors++; $display("FAIL sat_switch: got %b want 01", {bus.m0_gnt, bus.m1_gnt}); end
    clear_in();
    step();
  endtask

  task test_conflict;
    bus.m0_req = 1; bus.m0_read = 1; bus.m0_write = 1; bus.m0_addr = 32'h10;
    step();
    checks++; if ({bus.m_write, bus.m_read, bus.conflict} !== 3'b100) begin errors++; $display("FAIL conf_strobes: got %b want 100", {bus.m_write, bus.m_read, bus.conflict}); end
    checks++; if (bus.addr_bus !== 32'h10) begin errors++; $display("FAIL conf_addr: got %h want 10", bus.addr_bus); end
    step();
    checks++; if (bus.conflict !== 1'b1) begin errors++; $display("FAIL conf_set: got %b want 1", bus.conflict); end
    clear_in();
    step(); step();
    checks++; if (bus.conflict !== 1'b1) begin errors++; $display("FAIL conf_sticky: got %b want 1", bus.conflict); end
  endtask

  task test_reset_mid_burst;
    bus.m1_req = 1; bus.m1_write = 1; bus.m1_addr = 32'h44;
    step();
    checks++; if ({bus.m1_gnt, bus.m_write} !== 2'b11) begin errors++; $display("FAIL mid_own1: got %b want 11", {bus.m1_gnt, bus.m_write}); end
    #1 rst = 1;
    #1;
    checks++; if ({bus.m1_gnt, bus.m_write, bus.addr_bus, bus.conflict} !== 35'h0) begin errors++; $display("FAIL mid_async: got %h want 0", {bus.m1_gnt, bus.m_write, bus.addr_bus, bus.conflict}); end
    bus.m0_req = 1; bus.m0_read = 1; bus.m1_read = 1; bus.m1_write = 0;
    step();
    checks++; if ({bus.m0_gnt, bus.m1_gnt} !== 2'b00) begin errors++; $display("FAIL mid_held: got %b want 00", {bus.m0_gnt, bus.m1_gnt}); end
    rst = 0;
    step();
    checks++; if ({bus.m0_gnt, bus.m1_gnt} !== 2'b10) begin errors++; $display("FAIL mid_tie_m0: got %b want 10", {bus.m0_gnt, bus.m1_gnt}); end
    clear_in();
    step();
  endtask

  initial begin
    test_reset();
    test_tie_hold();
    test_read();
    test_round_robin();
    test_write_burst();
    test_handover();
    test_saturate();
    test_conflict();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
